// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store arbiter:
// RV32I load/store funct3 codes, FSM state encoding and a port-mask helper.
package dmem_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   // One-hot response/ready mask for a port index.
   function automatic logic [1:0] port_mask(input logic port);
      port_mask = port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane alignment for the 32-bit data BRAM.
// Store path turns right-aligned data into lane enables and replicated data;
// load path extracts and extends the addressed byte/half/word.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] dout,
   output logic [3:0]  st_we,
   output logic [31:0] st_din,
   output logic        st_err,
   output logic [31:0] ld_rdata,
   output logic        ld_err
);

   logic [31:0] lane_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Move the addressed lane down to bit 0 so byte/half extraction is uniform.
   always_comb begin
      lane_s = dout >> {offset, 3'b000};
      byte_s = lane_s[7:0];
      half_s = lane_s[15:0];
   end

   // Store lane enables, replicated data and legality check.
   always_comb begin
      st_we  = 4'b0000;
      st_din = 32'h0000_0000;
      st_err = 1'b0;
      case (funct3)
         SB: begin
            st_we  = 4'b0001 << offset;
            st_din = {4{wdata[7:0]}};
         end
         SH: begin
            if (offset[0]) begin
               st_err = 1'b1;
            end else begin
               st_we  = 4'b0011 << offset;
               st_din = {2{wdata[15:0]}};
            end
         end
         SW: begin
            if (offset != 2'b00) begin
               st_err = 1'b1;
            end else begin
               st_we  = 4'b1111;
               st_din = wdata;
            end
         end
         default: st_err = 1'b1;
      endcase
   end

   // Load extraction, sign/zero extension and legality check.
   always_comb begin
      ld_rdata = 32'h0000_0000;
      ld_err   = 1'b0;
      case (funct3)
         LB:  ld_rdata = {{24{byte_s[7]}}, byte_s};
         LBU: ld_rdata = {24'h00_0000, byte_s};
         LH: begin
            if (offset[0]) begin
               ld_err = 1'b1;
            end else begin
               ld_rdata = {{16{half_s[15]}}, half_s};
            end
         end
         LHU: begin
            if (offset[0]) begin
               ld_err = 1'b1;
            end else begin
               ld_rdata = {16'h0000, half_s};
            end
         end
         LW: begin
            if (offset != 2'b00) begin
               ld_err = 1'b1;
            end else begin
               ld_rdata = dout;
            end
         end
         default: ld_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_lsu_arbiter.sv
// Two-port controller for the 32-bit data BRAM. Arbitrates between the core
// LSU (port 0) and the debug loader (port 1), performs byte-lane alignment,
// hides the one-cycle BRAM read latency and returns a per-port response pulse.
module dmem_lsu_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter bit RR_EN  = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [1:0]              i_req_valid,
   output logic [1:0]              o_req_ready,
   input  logic [1:0]              i_req_we,
   input  logic [5:0]              i_req_funct3,
   input  logic [2*(ADDR_W+2)-1:0] i_req_addr,
   input  logic [63:0]             i_req_wdata,
   output logic [1:0]              o_rsp_valid,
   output logic [31:0]             o_rsp_rdata,
   output logic                    o_rsp_err,
   output logic [ADDR_W-1:0]       o_bram_addr,
   output logic [3:0]              o_bram_we,
   output logic [31:0]             o_bram_din,
   input  logic [31:0]             i_bram_dout
);

   localparam int BA_W = ADDR_W + 2;

   state_t        state_r, state_n;
   logic          last_grant_r, last_grant_n;
   logic          owner_r, owner_n;
   logic [2:0]    cap_f3_r, cap_f3_n;
   logic [1:0]    cap_off_r, cap_off_n;
   logic [1:0]    rsp_valid_r, rsp_valid_n;
   logic [31:0]   rsp_rdata_r, rsp_rdata_n;
   logic          rsp_err_r, rsp_err_n;

   logic          gnt_s;
   logic          accept_s;
   logic          sel_we_s;
   logic [2:0]    sel_f3_s;
   logic [BA_W-1:0] sel_addr_s;
   logic [31:0]   sel_wdata_s;
   logic [2:0]    aln_f3_s;
   logic [1:0]    aln_off_s;
   logic [3:0]    st_we_s;
   logic [31:0]   st_din_s;
   logic          st_err_s;
   logic [31:0]   ld_rdata_s;
   logic          ld_err_s;

   // Pick the winning port; on a contest round-robin favours the port not last granted.
   always_comb begin
      gnt_s = 1'b0;
      if (i_req_valid == 2'b11) begin
         gnt_s = RR_EN ? ~last_grant_r : 1'b0;
      end else if (i_req_valid[1]) begin
         gnt_s = 1'b1;
      end else begin
         gnt_s = 1'b0;
      end
   end

   // Route the granted port's request fields and drive ready/accept.
   always_comb begin
      sel_we_s    = gnt_s ? i_req_we[1]              : i_req_we[0];
      sel_f3_s    = gnt_s ? i_req_funct3[5:3]        : i_req_funct3[2:0];
      sel_addr_s  = gnt_s ? i_req_addr[2*BA_W-1:BA_W] : i_req_addr[BA_W-1:0];
      sel_wdata_s = gnt_s ? i_req_wdata[63:32]       : i_req_wdata[31:0];
      accept_s    = (state_r == IDLE) && (i_req_valid != 2'b00);
      if (accept_s) begin
         o_req_ready = port_mask(gnt_s);
      end else begin
         o_req_ready = 2'b00;
      end
   end

   // The aligner sees the live request in IDLE and the captured load in RD_WAIT.
   always_comb begin
      if (state_r == RD_WAIT) begin
         aln_f3_s  = cap_f3_r;
         aln_off_s = cap_off_r;
      end else begin
         aln_f3_s  = sel_f3_s;
         aln_off_s = sel_addr_s[1:0];
      end
   end

   dmem_lane_align u_align (
      .funct3   (aln_f3_s),
      .offset   (aln_off_s),
      .wdata    (sel_wdata_s),
      .dout     (i_bram_dout),
      .st_we    (st_we_s),
      .st_din   (st_din_s),
      .st_err   (st_err_s),
      .ld_rdata (ld_rdata_s),
      .ld_err   (ld_err_s)
   );

   // BRAM drive: write lanes only for an accepted legal store (aligner zeroes them on error).
   always_comb begin
      o_bram_addr = sel_addr_s[BA_W-1:2];
      o_bram_din  = st_din_s;
      if (accept_s && sel_we_s) begin
         o_bram_we = st_we_s;
      end else begin
         o_bram_we = 4'b0000;
      end
   end

   // FSM next state, load capture and response formation.
   always_comb begin
      state_n      = state_r;
      last_grant_n = last_grant_r;
      owner_n      = owner_r;
      cap_f3_n     = cap_f3_r;
      cap_off_n    = cap_off_r;
      rsp_valid_n  = 2'b00;
      rsp_rdata_n  = 32'h0000_0000;
      rsp_err_n    = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               last_grant_n = gnt_s;
               if (sel_we_s) begin
                  rsp_valid_n = port_mask(gnt_s);
                  rsp_err_n   = st_err_s;
               end else if (ld_err_s) begin
                  rsp_valid_n = port_mask(gnt_s);
                  rsp_err_n   = 1'b1;
               end else begin
                  owner_n   = gnt_s;
                  cap_f3_n  = sel_f3_s;
                  cap_off_n = sel_addr_s[1:0];
                  state_n   = RD_WAIT;
               end
            end else begin
               state_n = IDLE;
            end
         end
         RD_WAIT: begin
            rsp_valid_n = port_mask(owner_r);
            rsp_rdata_n = ld_rdata_s;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State, arbitration history, captured load context and registered response.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         owner_r      <= 1'b0;
         cap_f3_r     <= 3'b000;
         cap_off_r    <= 2'b00;
         rsp_valid_r  <= 2'b00;
         rsp_rdata_r  <= 32'h0000_0000;
         rsp_err_r    <= 1'b0;
      end else begin
         state_r      <= state_n;
         last_grant_r <= last_grant_n;
         owner_r      <= owner_n;
         cap_f3_r     <= cap_f3_n;
         cap_off_r    <= cap_off_n;
         rsp_valid_r  <= rsp_valid_n;
         rsp_rdata_r  <= rsp_rdata_n;
         rsp_err_r    <= rsp_err_n;
      end
   end

   assign o_rsp_valid = rsp_valid_r;
   assign o_rsp_rdata = rsp_rdata_r;
   assign o_rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_lsu_arbiter.sv
// Directed bench for dmem_lsu_arbiter: a round-robin instance drives a BRAM
// model; a fixed-priority instance shares the inputs for the priority check.
module tb_dmem_lsu_arbiter;
   import dmem_pkg::*;

   localparam int AW  = 10;
   localparam int BAW = AW + 2;

   logic             i_clk;
   logic             i_rst_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_we;
   logic [5:0]       req_f3;
   logic [2*BAW-1:0] req_addr;
   logic [63:0]      req_wdata;
   logic [31:0]      bram_dout;

   logic [1:0]       ready_a, rsp_valid_a;
   logic [31:0]      rdata_a, din_a;
   logic             err_a;
   logic [AW-1:0]    baddr_a;
   logic [3:0]       we_a;

   logic [1:0]       ready_b, rsp_valid_b;
   logic [31:0]      rdata_b, din_b;
   logic             err_b;
   logic [AW-1:0]    baddr_b;
   logic [3:0]       we_b;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] mem [0:1023];

   dmem_lsu_arbiter #(.ADDR_W(AW), .RR_EN(1'b1)) dut_rr (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(req_valid), .o_req_ready(ready_a),
      .i_req_we(req_we), .i_req_funct3(req_f3),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid_a), .o_rsp_rdata(rdata_a), .o_rsp_err(err_a),
      .o_bram_addr(baddr_a), .o_bram_we(we_a), .o_bram_din(din_a),
      .i_bram_dout(bram_dout)
   );

   dmem_lsu_arbiter #(.ADDR_W(AW), .RR_EN(1'b0)) dut_fp (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(req_valid), .o_req_ready(ready_b),
      .i_req_we(req_we), .i_req_funct3(req_f3),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid_b), .o_rsp_rdata(rdata_b), .o_rsp_err(err_b),
      .o_bram_addr(baddr_b), .o_bram_we(we_b), .o_bram_din(din_b),
      .i_bram_dout(bram_dout)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // BRAM model: byte-lane writes, one-cycle synchronous read.
   always @(posedge i_clk) begin
      for (int l = 0; l < 4; l++) begin
         if (we_a[l]) mem[baddr_a][l*8 +: 8] <= din_a[l*8 +: 8];
      end
      bram_dout <= mem[baddr_a];
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] pm(input int p);
      pm = (p == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   task automatic set_req(input int p, input logic we, input logic [2:0] f3,
                          input logic [BAW-1:0] addr, input logic [31:0] wd);
      req_valid[p]             = 1'b1;
      req_we[p]                = we;
      req_f3[p*3 +: 3]         = f3;
      req_addr[p*BAW +: BAW]   = addr;
      req_wdata[p*32 +: 32]    = wd;
   endtask

   task automatic clr();
      req_valid = 2'b00;
   endtask

   task automatic do_store(input string tag, input int p, input logic [2:0] f3,
                           input logic [BAW-1:0] addr, input logic [31:0] wd,
                           input logic [3:0] exp_we, input logic [31:0] exp_din);
      set_req(p, 1'b1, f3, addr, wd);
      #1;
      chk_eq({tag, "_ready"}, {30'd0, ready_a}, {30'd0, pm(p)});
      chk_eq({tag, "_we"},    {28'd0, we_a}, {28'd0, exp_we});
      chk_eq({tag, "_din"},   din_a, exp_din);
      chk_eq({tag, "_baddr"}, {22'd0, baddr_a}, {22'd0, addr[BAW-1:2]});
      tick();
      clr();
      #1;
      chk_eq({tag, "_rspv"}, {30'd0, rsp_valid_a}, {30'd0, pm(p)});
      chk_eq({tag, "_err"},  {31'd0, err_a}, 32'd0);
      chk_eq({tag, "_rdat"}, rdata_a, 32'd0);
   endtask

   task automatic do_load(input string tag, input int p, input logic [2:0] f3,
                          input logic [BAW-1:0] addr, input logic [31:0] exp_rdata);
      set_req(p, 1'b0, f3, addr, 32'd0);
      #1;
      chk_eq({tag, "_ready"}, {30'd0, ready_a}, {30'd0, pm(p)});
      chk_eq({tag, "_we"},    {28'd0, we_a}, 32'd0);
      chk_eq({tag, "_baddr"}, {22'd0, baddr_a}, {22'd0, addr[BAW-1:2]});
      tick();
      #1;
      chk_eq({tag, "_rdwait_ready"}, {30'd0, ready_a}, 32'd0);
      chk_eq({tag, "_rdwait_rspv"},  {30'd0, rsp_valid_a}, 32'd0);
      clr();
      tick();
      #1;
      chk_eq({tag, "_rspv"}, {30'd0, rsp_valid_a}, {30'd0, pm(p)});
      chk_eq({tag, "_rdat"}, rdata_a, exp_rdata);
      chk_eq({tag, "_err"},  {31'd0, err_a}, 32'd0);
   endtask

   task automatic do_err(input string tag, input int p, input logic we, input logic [2:0] f3,
                         input logic [BAW-1:0] addr);
      set_req(p, we, f3, addr, 32'hCAFE_F00D);
      #1;
      chk_eq({tag, "_ready"}, {30'd0, ready_a}, {30'd0, pm(p)});
      chk_eq({tag, "_we"},    {28'd0, we_a}, 32'd0);
      tick();
      clr();
      #1;
      chk_eq({tag, "_rspv"}, {30'd0, rsp_valid_a}, {30'd0, pm(p)});
      chk_eq({tag, "_err"},  {31'd0, err_a}, 32'd1);
      chk_eq({tag, "_rdat"}, rdata_a, 32'd0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
      i_rst_n   = 1'b0;
      req_valid = 2'b00;
      req_we    = 2'b00;
      req_f3    = 6'd0;
      req_addr  = '0;
      req_wdata = 64'd0;
      repeat (2) @(posedge i_clk);
      #2;
      chk_eq("rst_rspv",  {30'd0, rsp_valid_a}, 32'd0);
      chk_eq("rst_rdata", rdata_a, 32'd0);
      chk_eq("rst_err",   {31'd0, err_a}, 32'd0);
      chk_eq("rst_we",    {28'd0, we_a}, 32'd0);
      chk_eq("rst_ready", {30'd0, ready_a}, 32'd0);
      i_rst_n = 1'b1;
      tick();

      // 1: word store then word load.
      do_store("t1_sw", 0, SW, 12'h008, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
      do_load ("t1_lw", 0, LW, 12'h008, 32'hDEAD_BEEF);

      // 2: byte store into lane 3, then signed/unsigned extraction.
      do_store("t2_sb", 0, SB, 12'h00B, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
      do_load ("t2_lb",  0, LB,  12'h00B, 32'hFFFF_FFA5);
      do_load ("t2_lbu", 0, LBU, 12'h00B, 32'h0000_00A5);
      do_load ("t2_lh",  0, LH,  12'h00A, 32'hFFFF_A5AD);
      do_load ("t2_lhu", 0, LHU, 12'h008, 32'h0000_BEEF);

      // Port 1 store leaves last_grant = 1 so the contest below starts at port 0.
      do_store("p1_sh", 1, SH, 12'h00E, 32'h0000_1234, 4'b1100, 32'h1234_1234);

      // 3: both ports store every cycle.
      set_req(0, 1'b1, SW, 12'h010, 32'h1111_1111);
      set_req(1, 1'b1, SW, 12'h020, 32'h2222_2222);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_eq($sformatf("t3_rr_ready%0d", i), {30'd0, ready_a}, {30'd0, pm(i % 2)});
         chk_eq($sformatf("t3_rr_baddr%0d", i), {22'd0, baddr_a}, (i % 2 == 0) ? 32'd4 : 32'd8);
         chk_eq($sformatf("t3_fp_ready%0d", i), {30'd0, ready_b}, 32'd1);
         if (i > 0) begin
            chk_eq($sformatf("t3_rr_rspv%0d", i), {30'd0, rsp_valid_a}, {30'd0, pm((i - 1) % 2)});
         end
         tick();
      end
      clr();
      #1;
      chk_eq("t3_rr_rspv_last", {30'd0, rsp_valid_a}, 32'd2);
      chk_eq("t3_fp_rspv_last", {30'd0, rsp_valid_b}, 32'd1);
      tick();

      // 4: misaligned and illegal-funct3 accesses.
      do_err("t4_lh_mis",  0, 1'b0, LH,     12'h001);
      do_err("t4_sw_mis",  0, 1'b1, SW,     12'h006);
      do_err("t4_ld_f011", 0, 1'b0, 3'b011, 12'h000);
      do_err("t4_st_f100", 1, 1'b1, 3'b100, 12'h000);
      do_load("t4_mem_chk", 0, LW, 12'h004, 32'h0000_0000);

      // 5: reset while a load is in RD_WAIT.
      set_req(0, 1'b0, LW, 12'h008, 32'd0);
      #1;
      chk_eq("t5_ready", {30'd0, ready_a}, 32'd1);
      tick();
      clr();
      #1;
      i_rst_n = 1'b0;
      #1;
      chk_eq("t5_rst_rspv",  {30'd0, rsp_valid_a}, 32'd0);
      chk_eq("t5_rst_rdata", rdata_a, 32'd0);
      tick();
      #1;
      chk_eq("t5_no_rsp", {30'd0, rsp_valid_a}, 32'd0);
      i_rst_n = 1'b1;
      set_req(0, 1'b1, SW, 12'h030, 32'h0);
      set_req(1, 1'b1, SW, 12'h034, 32'h0);
      #1;
      chk_eq("t5_first_grant", {30'd0, ready_a}, 32'd1);
      tick();
      clr();
      #1;
      chk_eq("t5_rspv", {30'd0, rsp_valid_a}, 32'd1);
      tick();

      // 6: four back-to-back half-word stores, then a load.
      for (int k = 0; k < 4; k++) begin
         logic [15:0] h;
         h = 16'h1111 * (k + 1);
         set_req(0, 1'b1, SH, 12'h040 + 12'(2 * k), {16'h0, h});
         #1;
         chk_eq($sformatf("t6_ready%0d", k), {30'd0, ready_a}, 32'd1);
         chk_eq($sformatf("t6_we%0d", k), {28'd0, we_a}, (k % 2 == 0) ? 32'd3 : 32'd12);
         chk_eq($sformatf("t6_din%0d", k), din_a, {h, h});
         if (k > 0) chk_eq($sformatf("t6_rspv%0d", k - 1), {30'd0, rsp_valid_a}, 32'd1);
         tick();
      end
      set_req(0, 1'b0, LW, 12'h044, 32'd0);
      #1;
      chk_eq("t6_rspv3", {30'd0, rsp_valid_a}, 32'd1);
      chk_eq("t6_ld_ready", {30'd0, ready_a}, 32'd1);
      tick();
      #1;
      chk_eq("t6_rdwait_ready", {30'd0, ready_a}, 32'd0);
      clr();
      tick();
      #1;
      chk_eq("t6_ld_rspv", {30'd0, rsp_valid_a}, 32'd1);
      chk_eq("t6_ld_rdat", rdata_a, 32'h4444_3333);
      do_load("t6_lw16", 0, LW, 12'h040, 32'h2222_1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
